// File: rtl/lpc_excitation_gen_pkg.sv
// Shared types and helpers for the LPC excitation generator: FSM state, LFSR taps,
// minimum pitch period and a signed saturation helper.
package lpc_exc_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      VOICED   = 2'd1,
      UNVOICED = 2'd2
   } exc_state_t;

   localparam logic [15:0] LFSR_TAPS  = 16'hB400;
   localparam int          MIN_PERIOD = 2;

   // Clamp v to the signed range of a w-bit word; w must be 2..64.
   function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/lpc_excitation_gen_lfsr16.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) with seed parameter, enable and a
// guard that forces any all-zero state back to the seed.
module lpc_lfsr16
   import lpc_exc_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en_i,
   output logic [15:0] state_o
);

   logic [15:0] state_q;
   logic [15:0] state_d;
   logic [15:0] shifted;

   always_comb begin
      shifted = {1'b0, state_q[15:1]} ^ (state_q[0] ? LFSR_TAPS : 16'h0000);
      state_d = state_q;
      if (en_i) state_d = shifted;
      // zero is a lock-up state for an XOR LFSR
      if (state_d == 16'h0000) state_d = SEED;
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= SEED;
      else     state_q <= state_d;
   end

   assign state_o = state_q;

endmodule

// File: rtl/lpc_excitation_gen.sv
// LPC excitation source: gain-scaled pulse train (voiced) or LFSR noise (unvoiced),
// one sample per sample_en. Optional period jitter under macro LPC_EXC_JITTER_EN.
module lpc_excitation_gen
   import lpc_exc_pkg::*;
#(
   parameter int          DATA_W    = 16,
   parameter int          PERIOD_W  = 16,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       sample_en,
   input  logic                       param_load,
   input  logic                       voiced_in,
   input  logic [PERIOD_W-1:0]        pitch_in,
   input  logic [DATA_W-1:0]          gain_in,
   output logic signed [DATA_W-1:0]   exc_out,
   output logic                       exc_valid,
   output logic                       pulse_mark,
   output logic                       param_pending
);

   localparam int                PW        = 2 * DATA_W + 1;
   localparam logic [PERIOD_W:0] MIN_P     = (PERIOD_W + 1)'(MIN_PERIOD);
   localparam logic [PERIOD_W:0] ONE_P     = (PERIOD_W + 1)'(1);
   localparam logic [DATA_W-1:0] PULSE_MAX = {1'b0, {(DATA_W - 1){1'b1}}};

   exc_state_t          state_q, state_d;
   logic [PERIOD_W-1:0] count_q, count_d;
   logic [PERIOD_W:0]   period_q, period_d;
   logic                act_voiced_q, act_voiced_d, sh_voiced_q, sh_voiced_d;
   logic [PERIOD_W-1:0] act_pitch_q, act_pitch_d, sh_pitch_q, sh_pitch_d;
   logic [DATA_W-1:0]   act_gain_q, act_gain_d, sh_gain_q, sh_gain_d;
   logic                pending_q, pending_d;
   logic [DATA_W-1:0]   exc_q, exc_d;
   logic                valid_q, valid_d, mark_q, mark_d;

   logic [15:0]              lfsr;
   logic                     eff_voiced;
   logic [PERIOD_W-1:0]      eff_pitch;
   logic [DATA_W-1:0]        eff_gain;
   logic signed [DATA_W-1:0] noise_s;
   logic signed [PW-1:0]     noise_prod;
   logic signed [PW-1:0]     noise_shift;
   logic [DATA_W-1:0]        noise_val;
   logic [DATA_W-1:0]        pulse_val;
   logic [PERIOD_W:0]        p_base, p_next;
   logic                     commit, do_pulse, do_noise;

   lpc_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .en_i    (sample_en),
      .state_o (lfsr)
   );

   // A committing sample already runs on the shadow values.
   assign eff_voiced = pending_q ? sh_voiced_q : act_voiced_q;
   assign eff_pitch  = pending_q ? sh_pitch_q  : act_pitch_q;
   assign eff_gain   = pending_q ? sh_gain_q   : act_gain_q;

   generate
      if (DATA_W == 16) begin : g_noise_eq
         assign noise_s = lfsr;
      end else if (DATA_W > 16) begin : g_noise_wide
         assign noise_s = {lfsr, {(DATA_W - 16){1'b0}}};
      end else begin : g_noise_narrow
         assign noise_s = lfsr[15 -: DATA_W];
      end
   endgenerate

   assign noise_prod  = PW'(noise_s) * PW'($signed({1'b0, eff_gain}));
   assign noise_shift = noise_prod >>> (DATA_W - 1);
   assign noise_val   = DATA_W'(sat_s(64'(noise_shift), DATA_W));
   assign pulse_val   = eff_gain[DATA_W-1] ? PULSE_MAX : eff_gain;

   assign p_base = ({1'b0, eff_pitch} < MIN_P) ? MIN_P : {1'b0, eff_pitch};

`ifdef LPC_EXC_JITTER_EN
   logic [PERIOD_W:0] p_jit;
   always_comb begin
      case (lfsr[1:0])
         2'b00:   p_jit = p_base - ONE_P;
         2'b11:   p_jit = p_base + ONE_P;
         default: p_jit = p_base;
      endcase
      p_next = (p_jit < MIN_P) ? MIN_P : p_jit;
   end
`else
   assign p_next = p_base;
`endif

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      period_d     = period_q;
      act_voiced_d = act_voiced_q;
      act_pitch_d  = act_pitch_q;
      act_gain_d   = act_gain_q;
      sh_voiced_d  = sh_voiced_q;
      sh_pitch_d   = sh_pitch_q;
      sh_gain_d    = sh_gain_q;
      pending_d    = pending_q;
      exc_d        = exc_q;
      valid_d      = 1'b0;
      mark_d       = 1'b0;
      commit       = 1'b0;
      do_pulse     = 1'b0;
      do_noise     = 1'b0;

      if (sample_en) begin
         valid_d = 1'b1;
         case (state_q)
            VOICED: begin
               if (count_q == '0) begin
                  commit   = pending_q;
                  do_pulse = eff_voiced;
                  do_noise = !eff_voiced;
               end else begin
                  exc_d   = '0;
                  count_d = ({1'b0, count_q} == (period_q - ONE_P)) ? '0
                          : count_q + PERIOD_W'(1);
               end
            end
            UNVOICED: begin
               commit   = pending_q;
               do_pulse = eff_voiced;
               do_noise = !eff_voiced;
            end
            default: begin
               if (pending_q) begin
                  commit   = 1'b1;
                  do_pulse = eff_voiced;
                  do_noise = !eff_voiced;
               end else begin
                  exc_d = '0;
               end
            end
         endcase
      end

      if (do_pulse) begin
         state_d  = VOICED;
         exc_d    = pulse_val;
         mark_d   = 1'b1;
         count_d  = PERIOD_W'(1);
         period_d = p_next;
      end
      if (do_noise) begin
         state_d = UNVOICED;
         exc_d   = noise_val;
         count_d = '0;
      end
      if (commit) begin
         act_voiced_d = sh_voiced_q;
         act_pitch_d  = sh_pitch_q;
         act_gain_d   = sh_gain_q;
      end

      // A load in the same cycle as a commit refills the shadow and keeps it pending.
      if (param_load) begin
         sh_voiced_d = voiced_in;
         sh_pitch_d  = pitch_in;
         sh_gain_d   = gain_in;
         pending_d   = 1'b1;
      end else if (commit) begin
         pending_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         count_q      <= '0;
         period_q     <= '0;
         act_voiced_q <= 1'b0;
         act_pitch_q  <= '0;
         act_gain_q   <= '0;
         sh_voiced_q  <= 1'b0;
         sh_pitch_q   <= '0;
         sh_gain_q    <= '0;
         pending_q    <= 1'b0;
         exc_q        <= '0;
         valid_q      <= 1'b0;
         mark_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         period_q     <= period_d;
         act_voiced_q <= act_voiced_d;
         act_pitch_q  <= act_pitch_d;
         act_gain_q   <= act_gain_d;
         sh_voiced_q  <= sh_voiced_d;
         sh_pitch_q   <= sh_pitch_d;
         sh_gain_q    <= sh_gain_d;
         pending_q    <= pending_d;
         exc_q        <= exc_d;
         valid_q      <= valid_d;
         mark_q       <= mark_d;
      end
   end

   assign exc_out       = exc_q;
   assign exc_valid     = valid_q;
   assign pulse_mark    = mark_q;
   assign param_pending = pending_q;

endmodule

// File: tb/tb_lpc_excitation_gen.sv
// Self-checking bench for lpc_excitation_gen: expected samples are queued when a
// sample_en is driven and popped when the registered sample appears.
module tb_lpc_excitation_gen;

   localparam logic [15:0] SEED = 16'hACE1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sample_en = 1'b0;
   logic        param_load = 1'b0;
   logic        voiced_in = 1'b0;
   logic [15:0] pitch_in = 16'h0;
   logic [15:0] gain_in = 16'h0;
   logic [15:0] exc_out;
   logic        exc_valid;
   logic        pulse_mark;
   logic        param_pending;

   int errors = 0;
   int checks = 0;
   logic [15:0] lfsr_m = SEED;

   typedef struct packed {
      logic [15:0] exc;
      logic        mark;
   } exp_t;
   exp_t exp_q[$];
   exp_t exp_r;

   lpc_excitation_gen #(
      .DATA_W    (16),
      .PERIOD_W  (16),
      .LFSR_SEED (SEED)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .sample_en     (sample_en),
      .param_load    (param_load),
      .voiced_in     (voiced_in),
      .pitch_in      (pitch_in),
      .gain_in       (gain_in),
      .exc_out       (exc_out),
      .exc_valid     (exc_valid),
      .pulse_mark    (pulse_mark),
      .param_pending (param_pending)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      logic [15:0] n;
      n = l >> 1;
      if (l[0]) n = n ^ 16'hB400;
      return n;
   endfunction

   // Reference noise sample: signed LFSR times unsigned gain, >>> 15, saturated.
   function automatic logic [15:0] noise_exp(input logic [15:0] l, input logic [15:0] g);
      longint p;
      logic [63:0] pv;
      p = longint'($signed(l)) * longint'(g);
      p = p >>> 15;
      if (p > 32767) p = 32767;
      if (p < -32768) p = -32768;
      pv = p;
      return pv[15:0];
   endfunction

   task automatic tick(input logic se, input logic pl, input logic v,
                       input logic [15:0] p, input logic [15:0] g);
      sample_en  = se;
      param_load = pl;
      voiced_in  = v;
      pitch_in   = p;
      gain_in    = g;
      @(posedge clk);
      #1;
      if (rst)     lfsr_m = SEED;
      else if (se) lfsr_m = lfsr_step(lfsr_m);
      sample_en  = 1'b0;
      param_load = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      tick(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      rst = 1'b0;
      checks++; if (exc_out !== 16'h0) begin errors++; $display("FAIL reset_exc: got %h want 0000", exc_out); end
      checks++; if (exc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", exc_valid); end
      checks++; if (pulse_mark !== 1'b0) begin errors++; $display("FAIL reset_mark: got %b want 0", pulse_mark); end
      checks++; if (param_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b want 0", param_pending); end
      for (int s = 0; s < 5; s++) begin
         exp_q.push_back('{exc: 16'h0, mark: 1'b0});
         tick(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
         exp_r = exp_q.pop_front();
         checks++;
         if (exc_valid !== 1'b1 || exc_out !== exp_r.exc || pulse_mark !== exp_r.mark) begin
            errors++;
            $display("FAIL idle s=%0d: got v=%b exc=%h m=%b want v=1 exc=%h m=%b", s, exc_valid, exc_out, pulse_mark, exp_r.exc, exp_r.mark);
         end
         $display("idle   s=%0d exc=%h mark=%b", s, exc_out, pulse_mark);
      end
      tick(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      checks++; if (exc_valid !== 1'b0) begin errors++; $display("FAIL idle_novalid: got %b want 0", exc_valid); end
   endtask

   task automatic test_voiced();
      tick(1'b0, 1'b1, 1'b1, 16'd4, 16'h4000);
      checks++; if (param_pending !== 1'b1) begin errors++; $display("FAIL voiced_pending_set: got %b want 1", param_pending); end
      for (int s = 0; s < 16; s++) begin
         exp_q.push_back('{exc: (s % 4 == 0) ? 16'h4000 : 16'h0, mark: (s % 4 == 0)});
         tick(1'b1, 1'b0, 1'b1, 16'd4, 16'h4000);
         exp_r = exp_q.pop_front();
         checks++;
         if (exc_valid !== 1'b1 || exc_out !== exp_r.exc || pulse_mark !== exp_r.mark) begin
            errors++;
            $display("FAIL voiced s=%0d: got v=%b exc=%h m=%b want v=1 exc=%h m=%b", s, exc_valid, exc_out, pulse_mark, exp_r.exc, exp_r.mark);
         end
         $display("voiced s=%0d exc=%h mark=%b", s, exc_out, pulse_mark);
         if (s == 0) begin
            checks++; if (param_pending !== 1'b0) begin errors++; $display("FAIL voiced_commit: pending got %b want 0", param_pending); end
            tick(1'b0, 1'b0, 1'b1, 16'd4, 16'h4000);
            checks++;
            if (exc_valid !== 1'b0 || exc_out !== 16'h4000 || pulse_mark !== 1'b0) begin
               errors++;
               $display("FAIL voiced_hold: got v=%b exc=%h m=%b want v=0 exc=4000 m=0", exc_valid, exc_out, pulse_mark);
            end
         end
      end
   endtask

   task automatic test_pitch_change();
      for (int s = 0; s < 18; s++) begin
         exp_q.push_back('{exc: (s == 0 || s == 4 || s == 10 || s == 16) ? 16'h4000 : 16'h0,
                           mark: (s == 0 || s == 4 || s == 10 || s == 16)});
         tick(1'b1, s == 1, 1'b1, 16'd6, 16'h4000);
         exp_r = exp_q.pop_front();
         checks++;
         if (exc_valid !== 1'b1 || exc_out !== exp_r.exc || pulse_mark !== exp_r.mark) begin
            errors++;
            $display("FAIL pitch s=%0d: got v=%b exc=%h m=%b want v=1 exc=%h m=%b", s, exc_valid, exc_out, pulse_mark, exp_r.exc, exp_r.mark);
         end
         $display("pitch  s=%0d exc=%h mark=%b pend=%b", s, exc_out, pulse_mark, param_pending);
         if (s >= 1 && s <= 4) begin
            checks++;
            if (param_pending !== (s != 4)) begin
               errors++;
               $display("FAIL pitch_pending s=%0d: got %b want %b", s, param_pending, (s != 4));
            end
         end
      end
   endtask

   task automatic test_noise();
      int zero_dut;
      int zero_ref;
      logic [15:0] e;
      zero_dut = 0;
      zero_ref = 0;
      // samples 2..5 of the 6-sample period: still zero even though unvoiced is loaded
      for (int k = 2; k < 6; k++) begin
         exp_q.push_back('{exc: 16'h0, mark: 1'b0});
         tick(1'b1, k == 2, 1'b0, 16'd6, 16'h7FFF);
         exp_r = exp_q.pop_front();
         checks++;
         if (exc_valid !== 1'b1 || exc_out !== exp_r.exc || pulse_mark !== exp_r.mark) begin
            errors++;
            $display("FAIL noise_wait k=%0d: got v=%b exc=%h m=%b want v=1 exc=%h m=%b", k, exc_valid, exc_out, pulse_mark, exp_r.exc, exp_r.mark);
         end
         $display("nwait  k=%0d exc=%h pend=%b", k, exc_out, param_pending);
      end
      checks++; if (param_pending !== 1'b1) begin errors++; $display("FAIL noise_pending_hold: got %b want 1", param_pending); end
      for (int n = 0; n < 1000; n++) begin
         e = noise_exp(lfsr_m, 16'h7FFF);
         if (e == 16'h0) zero_ref++;
         exp_q.push_back('{exc: e, mark: 1'b0});
         tick(1'b1, 1'b0, 1'b0, 16'd6, 16'h7FFF);
         exp_r = exp_q.pop_front();
         if (exc_out === 16'h0) zero_dut++;
         checks++;
         if (exc_valid !== 1'b1 || exc_out !== exp_r.exc || pulse_mark !== exp_r.mark) begin
            errors++;
            $display("FAIL noise n=%0d: got v=%b exc=%h m=%b want v=1 exc=%h m=%b", n, exc_valid, exc_out, pulse_mark, exp_r.exc, exp_r.mark);
         end
         $display("noise  n=%0d exc=%h", n, exc_out);
         if (n == 0) begin
            checks++; if (param_pending !== 1'b0) begin errors++; $display("FAIL noise_commit: pending got %b want 0", param_pending); end
         end
      end
      checks++;
      if (zero_dut != zero_ref) begin
         errors++;
         $display("FAIL noise_nonzero: got %0d zero samples want %0d", zero_dut, zero_ref);
      end
      tick(1'b0, 1'b1, 1'b1, 16'd4, 16'h4000);
      exp_q.push_back('{exc: 16'h4000, mark: 1'b1});
      tick(1'b1, 1'b0, 1'b1, 16'd4, 16'h4000);
      exp_r = exp_q.pop_front();
      checks++;
      if (exc_valid !== 1'b1 || exc_out !== exp_r.exc || pulse_mark !== exp_r.mark) begin
         errors++;
         $display("FAIL noise_to_voiced: got v=%b exc=%h m=%b want v=1 exc=%h m=%b", exc_valid, exc_out, pulse_mark, exp_r.exc, exp_r.mark);
      end
      $display("revoice exc=%h mark=%b", exc_out, pulse_mark);
   endtask

   task automatic test_clamp_sat();
      logic pulse;
      for (int k = 0; k < 16; k++) begin
         pulse = (k >= 3) && (k % 2 == 1);
         exp_q.push_back('{exc: pulse ? ((k >= 11) ? 16'h7FFF : 16'h4000) : 16'h0, mark: pulse});
         tick(1'b1, (k == 0) || (k == 10), 1'b1, (k < 10) ? 16'd0 : 16'd1, (k < 10) ? 16'h4000 : 16'hFFFF);
         exp_r = exp_q.pop_front();
         checks++;
         if (exc_valid !== 1'b1 || exc_out !== exp_r.exc || pulse_mark !== exp_r.mark) begin
            errors++;
            $display("FAIL clamp k=%0d: got v=%b exc=%h m=%b want v=1 exc=%h m=%b", k, exc_valid, exc_out, pulse_mark, exp_r.exc, exp_r.mark);
         end
         $display("clamp  k=%0d exc=%h mark=%b", k, exc_out, pulse_mark);
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] e;
      rst = 1'b1;
      tick(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      rst = 1'b0;
      tick(1'b0, 1'b1, 1'b1, 16'd8, 16'h1234);
      for (int s = 0; s < 3; s++) begin
         exp_q.push_back('{exc: (s == 0) ? 16'h1234 : 16'h0, mark: (s == 0)});
         tick(1'b1, 1'b0, 1'b1, 16'd8, 16'h1234);
         exp_r = exp_q.pop_front();
         checks++;
         if (exc_valid !== 1'b1 || exc_out !== exp_r.exc || pulse_mark !== exp_r.mark) begin
            errors++;
            $display("FAIL rmid s=%0d: got v=%b exc=%h m=%b want v=1 exc=%h m=%b", s, exc_valid, exc_out, pulse_mark, exp_r.exc, exp_r.mark);
         end
         $display("rmid   s=%0d exc=%h mark=%b", s, exc_out, pulse_mark);
      end
      tick(1'b1, 1'b1, 1'b1, 16'd8, 16'h1234);
      checks++; if (exc_out !== 16'h0) begin errors++; $display("FAIL rmid_pre_exc: got %h want 0000", exc_out); end
      rst = 1'b1;
      tick(1'b1, 1'b1, 1'b1, 16'd8, 16'h5555);
      rst = 1'b0;
      checks++;
      if (exc_out !== 16'h0 || exc_valid !== 1'b0 || pulse_mark !== 1'b0 || param_pending !== 1'b0) begin
         errors++;
         $display("FAIL rmid_reset: got exc=%h v=%b m=%b p=%b want 0 0 0 0", exc_out, exc_valid, pulse_mark, param_pending);
      end
      exp_q.push_back('{exc: 16'h0, mark: 1'b0});
      tick(1'b1, 1'b0, 1'b0, 16'd0, 16'h0);
      exp_r = exp_q.pop_front();
      checks++;
      if (exc_valid !== 1'b1 || exc_out !== exp_r.exc || pulse_mark !== exp_r.mark) begin
         errors++;
         $display("FAIL rmid_idle: got v=%b exc=%h m=%b want v=1 exc=%h m=%b", exc_valid, exc_out, pulse_mark, exp_r.exc, exp_r.mark);
      end
      tick(1'b0, 1'b1, 1'b0, 16'd4, 16'h7FFF);
      e = noise_exp(lfsr_m, 16'h7FFF);
      exp_q.push_back('{exc: e, mark: 1'b0});
      tick(1'b1, 1'b0, 1'b0, 16'd4, 16'h7FFF);
      exp_r = exp_q.pop_front();
      checks++;
      if (exc_valid !== 1'b1 || exc_out !== exp_r.exc || pulse_mark !== exp_r.mark) begin
         errors++;
         $display("FAIL rmid_lfsr_seed: got v=%b exc=%h m=%b want v=1 exc=%h m=%b", exc_valid, exc_out, pulse_mark, exp_r.exc, exp_r.mark);
      end
      $display("rmid   seed-noise exc=%h", exc_out);
   endtask

   task automatic test_back_to_back();
      logic [15:0] e;
      tick(1'b0, 1'b1, 1'b1, 16'd4, 16'h4000);
      for (int s = 0; s < 5; s++) begin
         e = (s == 0) ? 16'h4000 : ((s == 4) ? noise_exp(lfsr_m, 16'h7FFF) : 16'h0);
         exp_q.push_back('{exc: e, mark: (s == 0)});
         tick(1'b1, s == 0, 1'b0, 16'd4, 16'h7FFF);
         exp_r = exp_q.pop_front();
         checks++;
         if (exc_valid !== 1'b1 || exc_out !== exp_r.exc || pulse_mark !== exp_r.mark) begin
            errors++;
            $display("FAIL b2b s=%0d: got v=%b exc=%h m=%b want v=1 exc=%h m=%b", s, exc_valid, exc_out, pulse_mark, exp_r.exc, exp_r.mark);
         end
         $display("b2b    s=%0d exc=%h mark=%b pend=%b", s, exc_out, pulse_mark, param_pending);
         checks++;
         if (param_pending !== (s != 4)) begin
            errors++;
            $display("FAIL b2b_pending s=%0d: got %b want %b", s, param_pending, (s != 4));
         end
      end
   endtask

   initial begin
      test_reset();
      test_voiced();
      test_pitch_change();
      test_noise();
      test_clamp_sat();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
